// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: parallel-in / serial-out bus of the UART transmitter.
// Handshake: the master raises Data_Valid with P_DATA/PAR_TYP stable around the
// rising CLK edge; the transmitter accepts only at an edge where Busy=0, and it
// then holds Busy=1 for the whole frame. A Data_Valid seen while Busy=1 is
// dropped: there is no queueing and no ready/ack pulse.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one UART frame per accepted byte, one bit per CLK
// (CLK is the baud clock). Frame = start(0), DATA_WIDTH bits LSB first,
// optional parity, stop(1). TX_OUT and Busy are registered.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit
// (PAR_TYP 0 = even, 1 = odd). Without it PAR_TYP is ignored.
// dbg_state exposes the FSM state register.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    uart_tx_serializer_if.slave        bus,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state_q, state_n;
    logic [3:0]            cnt_q, cnt_n;
    // Holding register, shifted right as bits go out so bit 0 is always next.
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
`ifdef UART_TX_PARITY_EN
    // Parity bit is computed once at acceptance, from the unshifted byte.
    logic                  par_q, par_n;
`endif

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
    assign dbg_state  = state_q;

    // Next state plus the registered line/busy value for the state being entered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    state_n = S_START;
                    data_n  = bus.P_DATA;
                    cnt_n   = 4'd0;
`ifdef UART_TX_PARITY_EN
                    par_n   = bus.PAR_TYP ^ (^bus.P_DATA);
`endif
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                state_n = S_DATA;
                cnt_n   = 4'd0;
                tx_n    = data_q[0];
                data_n  = data_q >> 1;
                busy_n  = 1'b1;
            end
            S_DATA: begin
                busy_n = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_n   = 4'd0;
`ifdef UART_TX_PARITY_EN
                    state_n = S_PARITY;
                    tx_n    = par_q;
`else
                    state_n = S_STOP;
                    tx_n    = 1'b1;
`endif
                end else begin
                    cnt_n  = cnt_q + 4'd1;
                    tx_n   = data_q[0];
                    data_n = data_q >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                state_n = S_STOP;
                tx_n    = 1'b1;
                busy_n  = 1'b1;
            end
`endif
            S_STOP: begin
                state_n = S_IDLE;
            end
            default: begin
                // Unused encodings fall back to an idle line.
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // State, holding registers and registered outputs; reset aborts any frame.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized bench for uart_tx_serializer. The expected
// line is built from the frame format (start, LSB-first data, optional parity,
// stop); a receiver model rebuilds the byte from the sampled line and a
// scoreboard queue holds the bytes that were sent.
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
module tb_uart_tx_serializer;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = W + 2 + (PAR ? 1 : 0);

    logic       CLK;
    logic       RST_n;
    logic [2:0] dbg_state;

    uart_tx_serializer_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line value of frame position j, straight from the frame format.
    function automatic logic frame_bit(input logic [W-1:0] d, input logic p, input int j);
        if (j == 0) return 1'b0;
        if (j <= W) return d[j-1];
        if (PAR && j == W + 1) return (^d) ^ p;
        return 1'b1;
    endfunction

    // Present a request at the falling edge; returns at accept edge + 1.
    task automatic request(input logic [W-1:0] d, input logic p, input bit hold);
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_TYP    = p;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) bus.Data_Valid = 1'b0;
    endtask

    // Called one time unit after the accept edge: checks all frame cycles,
    // then the idle cycle after STOP, and recovers the byte like a receiver.
    task automatic expect_frame(input logic [W-1:0] d, input logic p, input bit disturb);
        logic [W-1:0] rx;
        logic         rx_par;
        logic [W-1:0] exp_d;
        rx = '0;
        rx_par = 1'b0;
        exp_q.push_back(d);
        for (int j = 0; j < FL; j++) begin
            check("tx_bit", 32'(bus.TX_OUT), 32'(frame_bit(d, p, j)));
            check("busy_frame", 32'(bus.Busy), 32'd1);
            if (j >= 1 && j <= W) rx[j-1] = bus.TX_OUT;
            if (PAR && j == W + 1) rx_par = bus.TX_OUT;
            if (disturb) begin
                bus.Data_Valid = 1'($urandom_range(0, 1));
                bus.P_DATA     = W'($urandom);
                bus.PAR_TYP    = 1'($urandom_range(0, 1));
            end
            @(posedge CLK);
            #1;
        end
        check("idle_tx", 32'(bus.TX_OUT), 32'd1);
        check("idle_busy", 32'(bus.Busy), 32'd0);
        if (disturb) bus.Data_Valid = 1'b0;
        exp_d = exp_q.pop_front();
        check("rx_data", 32'(rx), 32'(exp_d));
        if (PAR) check("rx_parity_ok", 32'((^rx) ^ rx_par), 32'(p));
    endtask

    initial begin
        logic [W-1:0] d;
        logic         p;

        bus.P_DATA     = '0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b0;
        RST_n          = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("post_rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("post_rst_busy", 32'(bus.Busy), 32'd0);

        // Single frames, including the parity corner cases.
        request(8'hA5, 1'b0, 1'b0); expect_frame(8'hA5, 1'b0, 1'b0);
        request(8'hA5, 1'b1, 1'b0); expect_frame(8'hA5, 1'b1, 1'b0);
        request(8'h07, 1'b0, 1'b0); expect_frame(8'h07, 1'b0, 1'b0);
        request(8'h00, 1'b1, 1'b0); expect_frame(8'h00, 1'b1, 1'b0);
        request(8'hFF, 1'b0, 1'b0); expect_frame(8'hFF, 1'b0, 1'b0);

        // Requests and input changes while busy must be ignored.
        request(8'h3C, 1'b0, 1'b0);
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hFF;
        expect_frame(8'h3C, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("no_extra_tx", 32'(bus.TX_OUT), 32'd1);
            check("no_extra_busy", 32'(bus.Busy), 32'd0);
        end

        // Back-to-back with Data_Valid held high: one idle cycle between frames.
        request(8'h00, 1'b0, 1'b1);
        bus.P_DATA = 8'hFF;
        expect_frame(8'h00, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        expect_frame(8'hFF, 1'b0, 1'b0);

        // Reset during data bit 4, then a clean frame.
        request(8'h55, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        check("mid_bit4", 32'(bus.TX_OUT), 32'(frame_bit(8'h55, 1'b0, 5)));
        #2;
        RST_n = 1'b0;
        #1;
        check("abort_tx", 32'(bus.TX_OUT), 32'd1);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("abort_idle", 32'(bus.TX_OUT), 32'd1);
        request(8'h55, 1'b1, 1'b0); expect_frame(8'h55, 1'b1, 1'b0);

        // Random bytes through the receiver model, with random disturbance.
        repeat (256) begin
            d = W'($urandom);
            p = 1'($urandom_range(0, 1));
            request(d, p, 1'b0);
            expect_frame(d, p, 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
